// File: rtl/teclado_ctrl_pkg.sv
// Shared types and constants for the keyboard sequencing controller:
// prefix FSM states, scan-code constants, event layout and bus bit positions.
package teclado_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERRF = 8'hFF;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evento_t;

    // Event word layout seen by the processor.
    localparam int EV_VALID    = 31;
    localparam int EV_OVF      = 30;
    localparam int EV_CNT_MSB  = 29;
    localparam int EV_CNT_LSB  = 26;
    localparam int EV_BRK      = 9;
    localparam int EV_CODE_LSB = 0;

    // Control word bits.
    localparam int CW_POP     = 0;
    localparam int CW_FLUSH   = 1;
    localparam int CW_CLR_OVF = 2;
    localparam int CW_IRQ_EN  = 3;

endpackage

// File: rtl/fifo_teclado.sv
// Synchronous FIFO of key events. Push into a full queue is honoured only
// when a pop happens in the same cycle; flush overrides push and pop.
module fifo_teclado
    import teclado_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  evento_t    push_data,
    input  logic       pop,
    input  logic       flush,
    output evento_t    head,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    evento_t       mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 5'(FIFO_DEPTH));
    assign empty   = (count == 5'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + 5'(do_push) - 5'(do_pop);
        end
    end

    // NOTE: storage is not reset; count/empty gate every read of stale entries.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/teclado_ctrl.sv
// Keyboard sequencing controller: E0/F0 prefix FSM with timeout, event queue,
// sticky overflow, interrupt enable and processor-facing event word.
module teclado_ctrl
    import teclado_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  code_i,
    input  logic        code_new_i,
    input  logic        we_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] evento_o,
    output logic        irq_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tmo;
    logic          tmo_hit;
    logic          push_evt;
    evento_t       push_data;
    logic          pop;
    logic          flush;
    logic          clr_ovf;
    logic          ovf;
    logic          irq_en;
    evento_t       head;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          unused_bits;

    assign pop         = we_i & data_in_i[CW_POP];
    assign flush       = we_i & data_in_i[CW_FLUSH];
    assign clr_ovf     = we_i & data_in_i[CW_CLR_OVF];
    assign tmo_hit     = (tmo == TW'(TIMEOUT_CYC - 1));
    assign unused_bits = &{1'b0, data_in_i[31:4], count[4]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx  = state;
        push_evt  = 1'b0;
        push_data = '{brk: 1'b0, ext: 1'b0, code: code_i};
        if (code_new_i) begin
            if (code_i == CODE_ERR0 || code_i == CODE_ERRF) begin
                state_nx = ST_IDLE;
            end else if (code_i == CODE_EXT) begin
                state_nx = (state == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
            end else if (code_i == CODE_BRK) begin
                state_nx = (state == ST_EXT || state == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
            end else begin
                push_evt      = 1'b1;
                push_data.brk = (state == ST_BRK) || (state == ST_EXT_BRK);
                push_data.ext = (state == ST_EXT) || (state == ST_EXT_BRK);
                state_nx      = ST_IDLE;
            end
        end else if (state != ST_IDLE && tmo_hit) begin
            state_nx = ST_IDLE;
        end
    end

    // A waiting prefix only ages between strobes; a fresh byte restarts the wait.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                      tmo <= '0;
        else if (state == ST_IDLE || code_new_i || tmo_hit) tmo <= '0;
        else                                             tmo <= tmo + TW'(1);
    end

    // Set beats clear: an event lost in the clearing cycle must still be reported.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (push_evt && full && !pop && !flush) ovf <= 1'b1;
            else if (clr_ovf)                       ovf <= 1'b0;
            if (we_i) irq_en <= data_in_i[CW_IRQ_EN];
        end
    end

    fifo_teclado #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push_evt),
        .push_data(push_data),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        evento_o                        = '0;
        evento_o[EV_VALID]              = ~empty;
        evento_o[EV_OVF]                = ovf;
        evento_o[EV_CNT_MSB:EV_CNT_LSB] = count[3:0];
        if (!empty) evento_o[EV_BRK:EV_CODE_LSB] = head;
    end

    assign irq_o = ~empty & irq_en;

endmodule

// File: tb/tb_teclado_ctrl.sv
// Self-checking bench for teclado_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_teclado_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  code_i;
    logic        code_new_i;
    logic        we_i;
    logic [31:0] data_in_i;
    logic [31:0] evento_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending prefix flags and the event queue.
    logic [9:0] q[$];
    bit         m_ovf, m_irq_en, p_ext, p_brk;
    longint     edge_n, last_edge;

    teclado_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .code_i    (code_i),
        .code_new_i(code_new_i),
        .we_i      (we_i),
        .data_in_i (data_in_i),
        .evento_o  (evento_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ev();
        logic [31:0] v = '0;
        v[30] = m_ovf;
        if (q.size() > 0) begin
            v[31]    = 1'b1;
            v[29:26] = 4'(q.size());
            v[9:0]   = q[0];
        end
        return v;
    endfunction

    function automatic logic exp_irq();
        return (q.size() > 0) && m_irq_en;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_irq_en = 0; p_ext = 0; p_brk = 0;
        last_edge = edge_n;
    endtask

    task automatic model_edge(input bit s, input logic [7:0] c, input bit w, input logic [31:0] d);
        bit         push = 0, popped = 0, set = 0;
        logic [9:0] ev = '0;
        int         sz;
        edge_n++;
        if (s) begin
            if (c == 8'hE0) begin
                if (p_brk && !p_ext) p_brk = 0;
                p_ext = 1;
            end else if (c == 8'hF0) begin
                p_brk = 1;
            end else if (c == 8'h00 || c == 8'hFF) begin
                p_ext = 0; p_brk = 0;
            end else begin
                push = 1; ev = {p_brk, p_ext, c};
                p_ext = 0; p_brk = 0;
            end
            last_edge = edge_n;
        end else if ((p_ext || p_brk) && (edge_n - last_edge) >= TMO) begin
            p_ext = 0; p_brk = 0;
        end
        sz = q.size();
        if (w && d[1]) begin
            q.delete();
        end else begin
            if (w && d[0] && sz > 0) begin
                void'(q.pop_front());
                popped = 1;
            end
            if (push) begin
                if (sz < DEPTH || popped) q.push_back(ev);
                else set = 1;
            end
        end
        if (w && d[2]) m_ovf = 0;
        if (set)       m_ovf = 1;
        if (w)         m_irq_en = d[3];
    endtask

    task automatic cycle(input bit s, input logic [7:0] c, input bit w, input logic [31:0] d);
        code_new_i = s; code_i = c; we_i = w; data_in_i = d;
        @(posedge clk_i);
        model_edge(s, c, w, d);
        #1;
        code_new_i = 0; we_i = 0; data_in_i = '0;
        check("evento", evento_o, exp_ev());
        check("irq", {31'b0, irq_o}, {31'b0, exp_irq()});
    endtask

    task automatic strobe(input logic [7:0] c);
        cycle(1, c, 0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] d);
        cycle(0, 8'h00, 1, d);
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b0;
        #1;
        check("rst_evento", evento_o, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0; code_i = '0; code_new_i = 0; we_i = 0; data_in_i = '0;
        edge_n = 0;
        model_reset();
        #1;
        check("rst0_evento", evento_o, 32'h0);
        check("rst0_irq", {31'b0, irq_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Make, then break of the same key; pop reveals the break.
        strobe(8'h1C);
        check("make_1c", evento_o, 32'h8400001C);
        strobe(8'hF0); strobe(8'h1C);
        wr(32'h1);
        check("pop_break", evento_o, 32'h8400021C);
        wr(32'h1);
        check("empty_after_pops", evento_o, 32'h0);

        // Extended make then extended break.
        strobe(8'hE0); strobe(8'h75); strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
        check("ext_pair", evento_o, 32'h88000175);
        wr(32'h1);
        check("ext_break", evento_o, 32'h84000375);
        wr(32'h1);

        // Nine makes into an eight-deep queue.
        for (int i = 1; i <= 9; i++) strobe(8'(i));
        check("overflow_full", evento_o, 32'hE0000001);
        for (int i = 0; i < 8; i++) wr(32'h1);
        check("drained_ovf", evento_o, 32'h40000000);
        wr(32'h4);
        check("ovf_cleared", evento_o, 32'h0);

        // Full with simultaneous pop and push, then empty with pop and push.
        for (int i = 1; i <= 8; i++) strobe(8'(i));
        cycle(1, 8'h2A, 1, 32'h1);
        check("full_pop_push", evento_o, 32'hA0000002);
        wr(32'h2);
        check("flushed", evento_o, 32'h0);
        cycle(1, 8'h33, 1, 32'h1);
        check("empty_pop_push", evento_o, 32'h84000033);
        wr(32'h2);

        // Prefix expires before the next byte.
        strobe(8'hE0);
        for (int i = 0; i < TMO; i++) cycle(0, 8'h00, 0, 32'h0);
        strobe(8'h1C);
        check("timeout_make", evento_o, 32'h8400001C);
        wr(32'h2);

        // Interrupt enable, then flush racing a push.
        wr(32'h8);
        strobe(8'h1C);
        check("irq_on", {31'b0, irq_o}, 32'h1);
        cycle(1, 8'h2B, 1, 32'hA);
        check("flush_push_ev", evento_o, 32'h0);
        check("flush_push_irq", {31'b0, irq_o}, 32'h0);

        // Reset in the middle of a break prefix.
        strobe(8'h11);
        strobe(8'hF0);
        do_reset();
        strobe(8'h1C);
        check("post_rst_make", evento_o, 32'h8400001C);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          s, w;
            logic [7:0]  c;
            logic [31:0] d;
            int          r;
            if ($urandom_range(0, 99) == 0) begin
                for (int g = 0; g < TMO + 3; g++) cycle(0, 8'h00, 0, 32'h0);
            end
            s = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    c = 8'hE0;
                2, 3:    c = 8'hF0;
                4:       c = 8'h00;
                5:       c = 8'hFF;
                default: c = 8'($urandom);
            endcase
            w = ($urandom_range(0, 9) < 3);
            d = $urandom;
            d[1] = ($urandom_range(0, 15) == 0) && !s;
            cycle(s, c, w, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
